// File: rtl/dsp_pkg.sv
// Shared DSP control definitions: coefficient indices, Q1.15 width, biquad controller FSM encoding.
package dsp_pkg;

  localparam int unsigned Q15_WIDTH  = 16;
  localparam int unsigned NUM_COEFFS = 5;
  localparam int unsigned COEF_ID_W  = 3;

  localparam logic [COEF_ID_W-1:0] COEF_B0 = 3'd0;
  localparam logic [COEF_ID_W-1:0] COEF_B1 = 3'd1;
  localparam logic [COEF_ID_W-1:0] COEF_B2 = 3'd2;
  localparam logic [COEF_ID_W-1:0] COEF_A1 = 3'd3;
  localparam logic [COEF_ID_W-1:0] COEF_A2 = 3'd4;

  typedef enum logic [2:0] {
    BQC_IDLE  = 3'd0,
    BQC_ARMED = 3'd1,
    BQC_CLEAR = 3'd2,
    BQC_LOAD  = 3'd3,
    BQC_DONE  = 3'd4
  } bqc_state_e;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/biquad_coeff_ctrl_if.sv
// Host config, sample stream and coefficient-write bus of the biquad coefficient controller.
interface biquad_coeff_ctrl_if #(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned DATA_WIDTH  = 16
);
  logic                   cfg_wr;
  logic [2:0]             cfg_addr;
  logic [COEFF_WIDTH-1:0] cfg_data;
  logic                   commit;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  up_tdata;
  logic                   up_tvalid;
  logic                   up_tready;
  logic [DATA_WIDTH-1:0]  dn_tdata;
  logic                   dn_tvalid;
  logic                   dn_tready;
  logic                   coeff_wr;
  logic [2:0]             coeff_id;
  logic [COEFF_WIDTH-1:0] coeff_w;
  logic                   flt_clear;

  // Controller side.
  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, commit,
    input  up_tdata, up_tvalid, dn_tready,
    output busy, done, up_tready, dn_tdata, dn_tvalid,
    output coeff_wr, coeff_id, coeff_w, flt_clear
  );

  // Host / stream / filter side.
  modport master (
    output cfg_wr, cfg_addr, cfg_data, commit,
    output up_tdata, up_tvalid, dn_tready,
    input  busy, done, up_tready, dn_tdata, dn_tvalid,
    input  coeff_wr, coeff_id, coeff_w, flt_clear
  );
endinterface

// File: rtl/biquad_frame_counter.sv
// Modulo-FRAME_LEN stream handshake counter; last_sample flags the final sample slot of a frame.
module biquad_frame_counter
  import dsp_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic hs,
  output logic last_sample
);

  localparam int unsigned CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Advance on every handshake, wrapping after the last sample of the frame.
  always_comb begin
    cnt_d = cnt_q;
    if (hs) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_sample = (cnt_q == LAST_IDX);

endmodule

// File: rtl/biquad_coeff_ctrl.sv
// Biquad coefficient-update sequencer: shadow bank, snapshot, frame-aligned stall and
// five-write coefficient load so the filter never sees a mixed coefficient set.
// Optional: define BIQUAD_CTRL_STATE_CLEAR_EN to pulse flt_clear for CLR_CYCLES before the load.
module biquad_coeff_ctrl
  import dsp_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH = Q15_WIDTH,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRAME_LEN   = 1,
  parameter int unsigned CLR_CYCLES  = 2
) (
  input logic          clk,
  input logic          rst,
  biquad_coeff_ctrl_if.slave bus
);

  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("FRAME_LEN must be at least 1");
  end
  if (CLR_CYCLES < 1) begin : g_bad_clr_cycles
    $error("CLR_CYCLES must be at least 1");
  end

`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
  localparam bqc_state_e UPDATE_ST = BQC_CLEAR;
  localparam int unsigned CLR_W = cnt_width(CLR_CYCLES);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
`else
  localparam bqc_state_e UPDATE_ST = BQC_LOAD;
`endif
  // FRAME_LEN==1 needs no boundary wait, so commits go straight to the update.
  localparam bqc_state_e ENTRY_ST = (FRAME_LEN == 1) ? UPDATE_ST : BQC_ARMED;

  bqc_state_e state_q, state_d;

  logic [COEFF_WIDTH-1:0] shadow_q [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0] shadow_d [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0] snap_q   [NUM_COEFFS];
  logic [COEFF_WIDTH-1:0] snap_d   [NUM_COEFFS];

  logic                   pending_q, pending_d;
  logic [COEF_ID_W-1:0]   k_q, k_d;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   coeff_wr_q, coeff_wr_d;
  logic [COEF_ID_W-1:0]   coeff_id_q, coeff_id_d;
  logic [COEFF_WIDTH-1:0] coeff_w_q, coeff_w_d;

`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
  logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                   flt_clear_q, flt_clear_d;
`endif

  logic stream_gate;
  logic dn_hs;
  logic last_sample;

  // Stream passthrough, gated while the filter is being cleared or reloaded.
  assign stream_gate   = (state_q == BQC_LOAD) || (state_q == BQC_CLEAR);
  assign bus.dn_tdata  = bus.up_tdata;
  assign bus.dn_tvalid = bus.up_tvalid & ~stream_gate;
  assign bus.up_tready = bus.dn_tready & ~stream_gate;
  assign dn_hs         = bus.dn_tvalid & bus.dn_tready;

  // Frame position tracker for boundary-aligned commits.
  biquad_frame_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_cnt (
    .clk         (clk),
    .rst         (rst),
    .hs          (dn_hs),
    .last_sample (last_sample)
  );

  // Shadow writes, sequencing FSM and registered load-bus outputs.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    snap_d     = snap_q;
    pending_d  = pending_q;
    k_d        = k_q;
    coeff_id_d = coeff_id_q;
    coeff_w_d  = coeff_w_q;
`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
`endif

    for (int i = 0; i < NUM_COEFFS; i++) begin
      if (bus.cfg_wr && (bus.cfg_addr == COEF_ID_W'(i))) shadow_d[i] = bus.cfg_data;
    end

    case (state_q)
      BQC_IDLE: begin
        if (bus.commit) begin
          snap_d  = shadow_q;
          k_d     = COEF_B0;
          state_d = ENTRY_ST;
`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
          clr_cnt_d = '0;
`endif
        end
      end
      BQC_ARMED: begin
        if (bus.commit) pending_d = 1'b1;
        if (dn_hs && last_sample) state_d = UPDATE_ST;
      end
      BQC_CLEAR: begin
        if (bus.commit) pending_d = 1'b1;
`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
        if (clr_cnt_q == CLR_LAST) state_d = BQC_LOAD;
        else                       clr_cnt_d = clr_cnt_q + CLR_W'(1);
`else
        state_d = BQC_LOAD;
`endif
      end
      BQC_LOAD: begin
        if (bus.commit) pending_d = 1'b1;
        if (k_q == COEF_A2) state_d = BQC_DONE;
        else                k_d = k_q + COEF_ID_W'(1);
      end
      BQC_DONE: begin
        // A commit arriving in DONE is folded into the pending request.
        if (pending_q || bus.commit) begin
          pending_d = 1'b0;
          snap_d    = shadow_q;
          k_d       = COEF_B0;
          state_d   = ENTRY_ST;
`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
          clr_cnt_d = '0;
`endif
        end else begin
          state_d = BQC_IDLE;
        end
      end
      default: state_d = BQC_IDLE;
    endcase

    busy_d     = (state_d == BQC_ARMED) || (state_d == BQC_CLEAR) || (state_d == BQC_LOAD);
    done_d     = (state_d == BQC_DONE);
    coeff_wr_d = (state_d == BQC_LOAD);
    if (state_d == BQC_LOAD) begin
      coeff_id_d = k_d;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        if (k_d == COEF_ID_W'(i)) coeff_w_d = snap_d[i];
      end
    end
`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
    flt_clear_d = (state_d == BQC_CLEAR);
`endif
  end

  // State, bank and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BQC_IDLE;
      shadow_q   <= '{default: '0};
      snap_q     <= '{default: '0};
      pending_q  <= 1'b0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coeff_wr_q <= 1'b0;
      coeff_id_q <= '0;
      coeff_w_q  <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      snap_q     <= snap_d;
      pending_q  <= pending_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      coeff_wr_q <= coeff_wr_d;
      coeff_id_q <= coeff_id_d;
      coeff_w_q  <= coeff_w_d;
    end
  end

`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
  // Clear-pulse length counter and registered clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q   <= '0;
      flt_clear_q <= 1'b0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      flt_clear_q <= flt_clear_d;
    end
  end
  assign bus.flt_clear = flt_clear_q;
`else
  assign bus.flt_clear = 1'b0;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.coeff_wr = coeff_wr_q;
  assign bus.coeff_id = coeff_id_q;
  assign bus.coeff_w  = coeff_w_q;

endmodule

// File: tb/tb_biquad_coeff_ctrl.sv
// Directed bench for biquad_coeff_ctrl: one instance with FRAME_LEN=1, one with FRAME_LEN=4.
module tb_biquad_coeff_ctrl;
  import dsp_pkg::*;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 16;
`ifdef BIQUAD_CTRL_STATE_CLEAR_EN
  localparam int CLR = 2;
`else
  localparam int CLR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  biquad_coeff_ctrl_if #(.COEFF_WIDTH(CW), .DATA_WIDTH(DW)) if1 ();
  biquad_coeff_ctrl_if #(.COEFF_WIDTH(CW), .DATA_WIDTH(DW)) if4 ();

  biquad_coeff_ctrl #(.COEFF_WIDTH(CW), .DATA_WIDTH(DW), .FRAME_LEN(1), .CLR_CYCLES(2)) u_f1 (
    .clk (clk), .rst (rst), .bus (if1)
  );
  biquad_coeff_ctrl #(.COEFF_WIDTH(CW), .DATA_WIDTH(DW), .FRAME_LEN(4), .CLR_CYCLES(2)) u_f4 (
    .clk (clk), .rst (rst), .bus (if4)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_v [5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    if1.cfg_wr = 0; if1.cfg_addr = 0; if1.cfg_data = 0; if1.commit = 0;
    if1.up_tdata = 0; if1.up_tvalid = 0; if1.dn_tready = 1;
    if4.cfg_wr = 0; if4.cfg_addr = 0; if4.cfg_data = 0; if4.commit = 0;
    if4.up_tdata = 0; if4.up_tvalid = 0; if4.dn_tready = 1;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [15:0] d);
    if1.cfg_wr = 1; if1.cfg_addr = a; if1.cfg_data = d;
    adv();
    if1.cfg_wr = 0;
  endtask

  task automatic chk_st(input string tag, input logic wr, input logic bsy, input logic dn,
                        input logic clr, input logic rdy);
    chk({tag, ".coeff_wr"},  32'(if1.coeff_wr),  32'(wr));
    chk({tag, ".busy"},      32'(if1.busy),      32'(bsy));
    chk({tag, ".done"},      32'(if1.done),      32'(dn));
    chk({tag, ".flt_clear"}, 32'(if1.flt_clear), 32'(clr));
    chk({tag, ".up_tready"}, 32'(if1.up_tready), 32'(rdy));
  endtask

  // Checks the cycles following a commit on the FRAME_LEN=1 instance; optional
  // commit / b0-write injections at given LOAD indices.
  task automatic expect_load(input string tag, input int cm_a, input int cm_b, input int wr_k);
    for (int c = 0; c < CLR; c++) begin
      settle();
      chk_st($sformatf("%s.clr%0d", tag, c), 0, 1, 0, 1, 0);
      adv();
    end
    for (int k = 0; k < 5; k++) begin
      if1.commit = (k == cm_a) || (k == cm_b);
      if (k == wr_k) begin
        if1.cfg_wr = 1; if1.cfg_addr = 3'd0; if1.cfg_data = 16'h7FFF;
      end
      settle();
      chk_st($sformatf("%s.ld%0d", tag, k), 1, 1, 0, 0, 0);
      chk($sformatf("%s.ld%0d.id", tag, k), 32'(if1.coeff_id), 32'(k));
      chk($sformatf("%s.ld%0d.w", tag, k), 32'(if1.coeff_w), 32'(exp_v[k]));
      adv();
      if1.commit = 0; if1.cfg_wr = 0;
    end
    settle();
    chk_st({tag, ".done"}, 0, 0, 1, 0, 1);
    chk({tag, ".done.id_hold"}, 32'(if1.coeff_id), 32'd4);
    chk({tag, ".done.w_hold"}, 32'(if1.coeff_w), 32'(exp_v[4]));
    adv();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (3) adv();
    rst = 0;
    adv();

    // Reset state.
    settle();
    chk_st("rst", 0, 0, 0, 0, 1);
    chk("rst.coeff_id", 32'(if1.coeff_id), 32'd0);
    chk("rst.coeff_w", 32'(if1.coeff_w), 32'd0);
    if1.dn_tready = 0;
    settle();
    chk("rst.up_tready_follow", 32'(if1.up_tready), 32'd0);
    if1.dn_tready = 1;

    // Basic load, FRAME_LEN=1.
    wr1(3'd0, 16'h4000); wr1(3'd1, 16'h2000); wr1(3'd2, 16'h1000);
    wr1(3'd3, 16'hC000); wr1(3'd4, 16'h0800);
    exp_v = '{16'h4000, 16'h2000, 16'h1000, 16'hC000, 16'h0800};
    if1.commit = 1;
    settle();
    chk_st("t1.commit", 0, 0, 0, 0, 1);
    adv();
    if1.commit = 0;
    expect_load("t1", -1, -1, -1);
    settle();
    chk_st("t1.after", 0, 0, 0, 0, 1);

    // Frame-aligned commit, FRAME_LEN=4, continuous stream.
    if4.cfg_wr = 1; if4.cfg_addr = 3'd0; if4.cfg_data = 16'h0123;
    adv();
    if4.cfg_wr = 0;
    if4.up_tvalid = 1; if4.up_tdata = 16'd1;
    settle();
    chk("t2.s1.data", 32'(if4.dn_tdata), 32'd1);
    chk("t2.s1.rdy", 32'(if4.up_tready), 32'd1);
    adv();
    for (int s = 2; s <= 4; s++) begin
      if4.up_tdata = 16'(s);
      if4.commit = (s == 2);
      settle();
      chk($sformatf("t2.s%0d.data", s), 32'(if4.dn_tdata), 32'(s));
      chk($sformatf("t2.s%0d.valid", s), 32'(if4.dn_tvalid), 32'd1);
      chk($sformatf("t2.s%0d.rdy", s), 32'(if4.up_tready), 32'd1);
      chk($sformatf("t2.s%0d.wr", s), 32'(if4.coeff_wr), 32'd0);
      adv();
      if4.commit = 0;
    end
    if4.up_tdata = 16'd5;
    for (int c = 0; c < CLR; c++) begin
      settle();
      chk($sformatf("t2.clr%0d.rdy", c), 32'(if4.up_tready), 32'd0);
      chk($sformatf("t2.clr%0d.flt", c), 32'(if4.flt_clear), 32'd1);
      adv();
    end
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("t2.ld%0d.rdy", k), 32'(if4.up_tready), 32'd0);
      chk($sformatf("t2.ld%0d.valid", k), 32'(if4.dn_tvalid), 32'd0);
      chk($sformatf("t2.ld%0d.wr", k), 32'(if4.coeff_wr), 32'd1);
      chk($sformatf("t2.ld%0d.id", k), 32'(if4.coeff_id), 32'(k));
      chk($sformatf("t2.ld%0d.w", k), 32'(if4.coeff_w), (k == 0) ? 32'h0123 : 32'h0);
      adv();
    end
    settle();
    chk("t2.done", 32'(if4.done), 32'd1);
    chk("t2.s5.data", 32'(if4.dn_tdata), 32'd5);
    chk("t2.s5.valid", 32'(if4.dn_tvalid), 32'd1);
    chk("t2.s5.rdy", 32'(if4.up_tready), 32'd1);
    adv();
    if4.up_tvalid = 0;

    // Commit during LOAD queues one follow-up; extra commits collapse.
    if1.commit = 1;
    adv();
    if1.commit = 0;
    expect_load("t3a", 1, 3, 0);
    exp_v[0] = 16'h7FFF;
    expect_load("t3b", -1, -1, -1);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk_st($sformatf("t3.idle%0d", c), 0, 0, 0, 0, 1);
      adv();
    end

    // Reset during the third LOAD cycle aborts the sequence.
    if1.commit = 1;
    adv();
    if1.commit = 0;
    for (int c = 0; c < CLR + 2; c++) adv();
    settle();
    chk("t4.ld2.wr", 32'(if1.coeff_wr), 32'd1);
    chk("t4.ld2.id", 32'(if1.coeff_id), 32'd2);
    rst = 1;
    adv();
    rst = 0;
    settle();
    chk_st("t4.abort", 0, 0, 0, 0, 1);
    chk("t4.abort.id", 32'(if1.coeff_id), 32'd0);
    if1.dn_tready = 0;
    settle();
    chk("t4.abort.rdy_follow", 32'(if1.up_tready), 32'd0);
    if1.dn_tready = 1;
    for (int c = 0; c < 8; c++) begin
      adv();
      settle();
      chk_st($sformatf("t4.quiet%0d", c), 0, 0, 0, 0, 1);
    end

    // Out-of-range addresses leave the bank untouched.
    wr1(3'd0, 16'h1111); wr1(3'd1, 16'h2222); wr1(3'd2, 16'h3333);
    wr1(3'd3, 16'h4444); wr1(3'd4, 16'h5555);
    wr1(3'd6, 16'h1234); wr1(3'd5, 16'h1234); wr1(3'd7, 16'h1234);
    exp_v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    if1.commit = 1;
    adv();
    if1.commit = 0;
    expect_load("t6", -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
